fios_result_collector: RTL and testbench

Collects the 34-bit products streamed out of a PE arithmetic unit (17x17 multiply-add DSP wrapper) during one FIOS multiplication. Splits each product into a 17-bit result word and a 17-bit carry fed back to the AU C input. Assembles the result words into one wide register and hands it downstream with a valid/ready handshake. Sits directly downstream of the PE arithmetic unit, in the same PE.

---
 rtl/fios_result_collector.sv | 133 +++++++++++++
 tb/tb_fios_result_collector.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fios_result_collector.sv
// FIOS result collector: splits the 34-bit AU products of one FIOS multiplication
// into 17-bit result words and 17-bit carries. It assembles the S+1 result words and
// hands them downstream over a valid/ready handshake.
module fios_result_collector #(
  parameter int unsigned S   = 8,
  parameter int unsigned LAT = 3
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  issue_i,
  input  logic [33:0]           P_i,
  output logic [16:0]           carry_o,
  output logic                  carry_valid_o,
  output logic [17*(S+1)-1:0]   result_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  overflow_o,
  output logic                  busy_o
);

  localparam int unsigned CntW = $clog2(S + 1);
  localparam logic [CntW-1:0] SCnt  = CntW'(S);
  localparam logic [CntW-1:0] SLast = CntW'(S - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]     cap_cnt_q, cap_cnt_d;
  logic [LAT-1:0]      vld_q, vld_d;
  logic [16:0]         carry_q;
  logic                carry_valid_q;
  logic [17*(S+1)-1:0] result_q;
  logic                overflow_q;

  logic accept;
  logic capture;
  logic last_cap;

  // Issue acceptance, and capture when the matching delay-line entry exits
  always_comb begin
    accept   = issue_i && (state_q != StDone) && (issue_cnt_q < SCnt);
    capture  = vld_q[LAT-1];
    last_cap = capture && (cap_cnt_q == SLast);
    // Shifting left also covers LAT == 1, where the line is a single flop
    vld_d    = vld_q << 1;
    vld_d[0] = accept;
  end

  // Next-state and count update
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    if (accept) issue_cnt_d = issue_cnt_q + 1'b1;
    if (capture) cap_cnt_d = cap_cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StCollect;
      end
      StCollect: begin
        if (last_cap) state_d = StDone;
      end
      StDone: begin
        // No issue is accepted and no capture happens in DONE, so clearing is safe
        if (result_ready_i) begin
          state_d     = StIdle;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and the valid delay line
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      vld_q       <= vld_d;
    end
  end

  // Carry register, with a one-cycle pulse that drives the AU CREG enable
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      carry_q       <= '0;
      carry_valid_q <= 1'b0;
    end else begin
      carry_valid_q <= capture;
      if (capture) carry_q <= P_i[33:17];
    end
  end

  // Result assembly; the final carry becomes the top word
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      result_q <= '0;
    end else if (capture) begin
      for (int k = 0; k < S; k++) begin
        if (cap_cnt_q == CntW'(k)) result_q[17*k +: 17] <= P_i[16:0];
      end
      if (last_cap) result_q[17*S +: 17] <= P_i[33:17];
    end
  end

  // Sticky flag for dropped issues
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
    end else if (issue_i && !accept) begin
      overflow_q <= 1'b1;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    carry_o        = carry_q;
    carry_valid_o  = carry_valid_q;
    result_o       = result_q;
    result_valid_o = (state_q == StDone);
    overflow_o     = overflow_q;
    busy_o         = (state_q != StIdle);
  end

endmodule

// File: tb/tb_fios_result_collector.sv
// Scoreboard bench for fios_result_collector. Stimulus pushes expected carries and
// results (with their expected cycles) into queues. A monitor pops and checks them
// whenever the DUT presents a carry pulse or a result.
module tb_fios_result_collector;

  localparam int S   = 8;
  localparam int LAT = 3;
  localparam int RW  = 17 * (S + 1);
  localparam logic [33:0] JUNK = 34'h2BADF00D1;

  typedef struct {
    logic [16:0] v;
    int          cyc;
  } carry_t;

  typedef struct {
    logic [RW-1:0] v;
    int            rise;
    int            fall;
  } res_t;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          issue_i;
  logic [33:0]   P_i;
  logic [16:0]   carry_o;
  logic          carry_valid_o;
  logic [RW-1:0] result_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic          overflow_o;
  logic          busy_o;

  int     cyc   = 0;
  int     tests = 0;
  int     fails = 0;
  carry_t cq[$];
  res_t   rq[$];
  int     iss_tab[S];
  bit     rv_prev = 1'b0;
  res_t   cur;

  fios_result_collector #(.S(S), .LAT(LAT)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .issue_i        (issue_i),
    .P_i            (P_i),
    .carry_o        (carry_o),
    .carry_valid_o  (carry_valid_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .overflow_o     (overflow_o),
    .busy_o         (busy_o)
  );

  always #5 clock_i = ~clock_i;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [16:0] hi_val(input int vset, input int k);
    return (vset == 0) ? 17'(k + 1) : 17'(17'h1F000 + 5 * k);
  endfunction

  function automatic logic [16:0] lo_val(input int vset, input int k);
    return (vset == 0) ? 17'(256 + k) : 17'(17'h0ABC0 + 3 * k);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_carry"}, RW'(carry_o), '0);
    chk({tag, "_carry_valid"}, RW'(carry_valid_o), '0);
    chk({tag, "_result"}, result_o, '0);
    chk({tag, "_result_valid"}, RW'(result_valid_o), '0);
    chk({tag, "_overflow"}, RW'(overflow_o), '0);
    chk({tag, "_busy"}, RW'(busy_o), '0);
  endtask

  // Asynchronous reset applied mid-cycle, away from any clock edge
  task automatic do_reset();
    @(negedge clock_i);
    #2;
    reset_i = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
  endtask

  // One operand: issues at iss_tab (relative cycles), an extra dropped issue at 'drop',
  // ready held high from 'ready_cyc', optional reset at 'rst_cyc'.
  task automatic run_op(input int drop, input int ready_cyc, input int rst_cyc,
                        input int ncyc, input int vset);
    int            t0;
    int            vc;
    logic [RW-1:0] r;
    carry_t        ce;
    res_t          re;
    t0 = cyc;
    r  = '0;
    for (int k = 0; k < S; k++) begin
      ce.v   = hi_val(vset, k);
      ce.cyc = t0 + iss_tab[k] + LAT + 1;
      if (rst_cyc < 0 || iss_tab[k] + LAT + 1 < rst_cyc) cq.push_back(ce);
      r[17*k +: 17] = lo_val(vset, k);
    end
    r[17*S +: 17] = hi_val(vset, S - 1);
    if (rst_cyc < 0) begin
      vc      = iss_tab[S-1] + LAT + 1;
      re.v    = r;
      re.rise = t0 + vc;
      re.fall = t0 + ((vc > ready_cyc) ? vc : ready_cyc) + 1;
      rq.push_back(re);
    end
    for (int c = 0; c < ncyc; c++) begin
      issue_i        = 1'b0;
      P_i            = JUNK;
      result_ready_i = (c >= ready_cyc);
      for (int k = 0; k < S; k++) begin
        if (iss_tab[k] == c && (rst_cyc < 0 || c < rst_cyc)) issue_i = 1'b1;
        if (iss_tab[k] + LAT == c) P_i = {hi_val(vset, k), lo_val(vset, k)};
      end
      if (c == drop) issue_i = 1'b1;
      if (c == rst_cyc) begin
        reset_i = 1'b1;
        #1;
        check_zero("mid_op_reset");
      end
      @(negedge clock_i);
      if (drop >= 0 && c == drop) chk("overflow_before_drop", RW'(overflow_o), '0);
      if (drop >= 0 && c == drop + 1) chk("overflow_after_drop", RW'(overflow_o), RW'(1));
      if (c == rst_cyc) begin
        #1;
        reset_i = 1'b0;
      end
      @(posedge clock_i);
      #1;
    end
    issue_i        = 1'b0;
    result_ready_i = 1'b0;
    chk("carry_pending", RW'(cq.size()), '0);
    chk("result_pending", RW'(rq.size()), '0);
    chk("idle_at_end", RW'(busy_o), '0);
  endtask

  // Monitor: checks every carry pulse and every result presentation against the queues
  always @(negedge clock_i) begin
    carry_t ce;
    if (reset_i) begin
      rv_prev = 1'b0;
    end else begin
      if (carry_valid_o) begin
        if (cq.size() == 0) begin
          chk("unexpected_carry", RW'(carry_o), '1);
        end else begin
          ce = cq.pop_front();
          chk("carry_value", RW'(carry_o), RW'(ce.v));
          chk("carry_cycle", RW'(cyc), RW'(ce.cyc));
        end
      end
      if (result_valid_o && !rv_prev) begin
        if (rq.size() == 0) begin
          chk("unexpected_result", result_o, '1);
        end else begin
          cur = rq.pop_front();
          chk("result_value", result_o, cur.v);
          chk("result_rise_cycle", RW'(cyc), RW'(cur.rise));
        end
      end else if (result_valid_o) begin
        chk("result_stable", result_o, cur.v);
      end
      if (!result_valid_o && rv_prev) chk("result_fall_cycle", RW'(cyc), RW'(cur.fall));
      rv_prev = result_valid_o;
    end
  end

  initial begin
    reset_i        = 1'b1;
    issue_i        = 1'b0;
    P_i            = '0;
    result_ready_i = 1'b0;
    #1;
    check_zero("power_on_reset");
    repeat (2) @(posedge clock_i);
    #1;
    reset_i = 1'b0;

    iss_tab = '{0, 1, 2, 3, 4, 5, 6, 7};
    // Back-to-back issues, ready always high
    run_op(-1, 0, -1, 16, 0);
    do_reset();
    // Ninth issue in the same operand is dropped
    run_op(8, 0, -1, 16, 0);
    do_reset();
    // Backpressure until cycle 20, issue in DONE at cycle 15 dropped
    run_op(15, 20, -1, 24, 0);
    do_reset();
    // Sparse issues with a second value set
    iss_tab = '{0, 5, 6, 20, 21, 25, 30, 31};
    run_op(-1, 0, -1, 40, 1);
    do_reset();
    // Reset at cycle 6 mid-collection, then a clean operand
    iss_tab = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_op(-1, 0, 6, 14, 0);
    run_op(-1, 0, -1, 16, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
